// File: rtl/rv32i_mc_control_fsm.sv
// Main sequencer for the RV32I multicycle core.
// It steps each instruction through fetch, decode, execute, memory and write-back.
// It drives the datapath enables, the mux selects and alu_op for the ALU control decoder.
// It also builds the {funct7[5],funct3} func field that the same decoder uses.
// Ports:
//   clk, rst_n               core clock (rising edge) and asynchronous active-low reset
//   opcode/funct3/funct7_5   instruction register fields, valid from S_DECODE onward
//   mem_ready                memory completes the current read or write in this cycle
//   alu_op, func             inputs to the ALU control decoder
//   pc_write, pc_write_cond  PC load strobes; pc_write_cond is gated by branch-taken
//   ir_write                 latches the instruction register
//   mem_read, mem_write      memory request strobes
//   iord                     memory address select: 0 = PC, 1 = ALUOut
//   reg_write                register file write strobe
//   alu_src_a, alu_src_b     ALU operand selects
//   mem_to_reg, pc_src       write-back data select and next-PC select
//   illegal                  sticky flag, set by an unknown opcode and cleared only by reset
//   state_o                  current state encoding, for debug
// Latency: all outputs except func and the fetch-completion strobes are Moore outputs of the state register.
// Backpressure: memory states wait for mem_ready, so wait states of any length are accepted.

module rv32i_mc_control_fsm #(
  parameter int unsigned RESET_PC_HOLD = 1  // cycles spent in S_IDLE after reset release (1..15)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       mem_ready,
  output logic [1:0] alu_op,
  output logic [3:0] func,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] mem_to_reg,
  output logic [1:0] pc_src,
  output logic       illegal,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_EXEC_I   = 4'd4,
    S_ALU_WB   = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_MEM_WB   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JAL      = 4'd11,
    S_JALR     = 4'd12,
    S_LUI      = 4'd13,
    S_AUIPC    = 4'd14,
    S_ILLEGAL  = 4'd15
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // The counter ends on the last idle cycle, so a hold of 1 gives one idle cycle.
  localparam logic [3:0] HOLD_LAST = 4'(RESET_PC_HOLD - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] hold_cnt;
  logic [3:0] hold_cnt_nxt;
  logic       illegal_q;
  logic       f7b;

  // State register, idle hold counter and sticky illegal flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      hold_cnt  <= 4'd0;
      illegal_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_cnt_nxt;
      if (state_nxt == S_ILLEGAL) begin
        illegal_q <= 1'b1;
      end
    end
  end

  // funct7[5] is meaningful only for R-type and for the SRLI/SRAI shifts.
  // Every other I-type has immediate bits in that position.
  // For example, ADDI with a negative immediate must not decode as SUB.
  always_comb begin
    f7b = 1'b0;
    if (opcode == OP_R) begin
      f7b = funct7_5;
    end else if ((opcode == OP_IMM) && (funct3 == 3'b101)) begin
      f7b = funct7_5;
    end
  end

  assign func    = {f7b, funct3};
  assign illegal = illegal_q;
  assign state_o = state;

  // Next-state and output decode.
  always_comb begin
    state_nxt     = state;
    hold_cnt_nxt  = 4'd0;
    alu_op        = 2'b00;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    iord          = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    mem_to_reg    = 2'b00;
    pc_src        = 2'b00;

    case (state)
      S_IDLE: begin
        if (hold_cnt >= HOLD_LAST) begin
          state_nxt = S_FETCH;
        end else begin
          hold_cnt_nxt = hold_cnt + 4'd1;
        end
      end

      S_FETCH: begin
        // The ALU computes PC+4 while the read is outstanding.
        // The IR and PC are committed only in the cycle where memory completes.
        mem_read  = 1'b1;
        alu_src_a = 2'b00;
        alu_src_b = 2'b01;
        alu_op    = 2'b01;
        if (mem_ready) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          pc_src    = 2'b00;
          state_nxt = S_DECODE;
        end
      end

      S_DECODE: begin
        // oldPC + imm is computed here so that a branch or JAL target sits in ALUOut next cycle.
        alu_src_a = 2'b10;
        alu_src_b = 2'b10;
        alu_op    = 2'b01;
        case (opcode)
          OP_R:               state_nxt = S_EXEC_R;
          OP_IMM:             state_nxt = S_EXEC_I;
          OP_LOAD, OP_STORE:  state_nxt = S_MEM_ADDR;
          OP_BRANCH:          state_nxt = S_BRANCH;
          OP_JAL:             state_nxt = S_JAL;
          OP_JALR:            state_nxt = S_JALR;
          OP_LUI:             state_nxt = S_LUI;
          OP_AUIPC:           state_nxt = S_AUIPC;
          default:            state_nxt = S_ILLEGAL;
        endcase
      end

      S_EXEC_R: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b00;
        alu_op    = 2'b10;
        state_nxt = S_ALU_WB;
      end

      S_EXEC_I: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        alu_op    = 2'b10;
        state_nxt = S_ALU_WB;
      end

      S_ALU_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b00;
        state_nxt  = S_FETCH;
      end

      S_MEM_ADDR: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        alu_op    = 2'b01;
        state_nxt = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      end

      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) begin
          state_nxt = S_MEM_WB;
        end
      end

      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b01;
        state_nxt  = S_FETCH;
      end

      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) begin
          state_nxt = S_FETCH;
        end
      end

      S_BRANCH: begin
        // The ALU compares rs1 with rs2, and the datapath gates pc_write_cond with the result.
        // The target comes from ALUOut, which was computed during decode.
        alu_src_a     = 2'b01;
        alu_src_b     = 2'b00;
        alu_op        = 2'b11;
        pc_write_cond = 1'b1;
        pc_src        = 2'b01;
        state_nxt     = S_FETCH;
      end

      S_JAL: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b10;
        pc_write   = 1'b1;
        pc_src     = 2'b01;
        alu_op     = 2'b00;
        state_nxt  = S_FETCH;
      end

      S_JALR: begin
        // rs1 + imm with bit 0 cleared goes straight to the PC.
        // The link value PC+4 is written back in the same cycle.
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        alu_op     = 2'b01;
        pc_write   = 1'b1;
        pc_src     = 2'b10;
        reg_write  = 1'b1;
        mem_to_reg = 2'b10;
        state_nxt  = S_FETCH;
      end

      S_LUI: begin
        alu_src_a = 2'b11;
        alu_src_b = 2'b10;
        alu_op    = 2'b01;
        state_nxt = S_ALU_WB;
      end

      S_AUIPC: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b10;
        alu_op    = 2'b01;
        state_nxt = S_ALU_WB;
      end

      S_ILLEGAL: begin
        // Trap here until reset. No PC or register write is issued.
        state_nxt = S_ILLEGAL;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_rv32i_mc_control_fsm.sv
// Self-checking bench for rv32i_mc_control_fsm.
// Per-cycle expected outputs are written by hand into a vector table.
// Each vector's expectation is queued when its inputs are driven and compared on the following falling edge.
// Reset and abort corner cases are written as separate, hand-coded sequences.

module tb_rv32i_mc_control_fsm;

  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_FETCH = 4'd1;
  localparam logic [3:0] ST_DEC   = 4'd2;
  localparam logic [3:0] ST_EXR   = 4'd3;
  localparam logic [3:0] ST_EXI   = 4'd4;
  localparam logic [3:0] ST_AWB   = 4'd5;
  localparam logic [3:0] ST_MADDR = 4'd6;
  localparam logic [3:0] ST_MRD   = 4'd7;
  localparam logic [3:0] ST_MWB   = 4'd8;
  localparam logic [3:0] ST_MWR   = 4'd9;
  localparam logic [3:0] ST_BR    = 4'd10;
  localparam logic [3:0] ST_JAL   = 4'd11;
  localparam logic [3:0] ST_JALR  = 4'd12;
  localparam logic [3:0] ST_LUI   = 4'd13;
  localparam logic [3:0] ST_AUIPC = 4'd14;
  localparam logic [3:0] ST_ILL   = 4'd15;

  typedef struct packed {
    logic [3:0] st;
    logic [1:0] aop;
    logic [3:0] fn;
    logic       pw;
    logic       pwc;
    logic       irw;
    logic       mr;
    logic       mw;
    logic       io;
    logic       rw;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [1:0] m2r;
    logic [1:0] ps;
    logic       ill;
  } outs_t;

  typedef struct packed {
    logic [6:0] opc;
    logic [2:0] f3;
    logic       f7;
    logic       rdy;
    outs_t      exp;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       mem_ready;
  logic [1:0] alu_op;
  logic [3:0] func;
  logic       pc_write;
  logic       pc_write_cond;
  logic       ir_write;
  logic       mem_read;
  logic       mem_write;
  logic       iord;
  logic       reg_write;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] mem_to_reg;
  logic [1:0] pc_src;
  logic       illegal;
  logic [3:0] state_o;

  rv32i_mc_control_fsm #(.RESET_PC_HOLD(1)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .funct3        (funct3),
    .funct7_5      (funct7_5),
    .mem_ready     (mem_ready),
    .alu_op        (alu_op),
    .func          (func),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .ir_write      (ir_write),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .iord          (iord),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .mem_to_reg    (mem_to_reg),
    .pc_src        (pc_src),
    .illegal       (illegal),
    .state_o       (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  outs_t act;
  assign act = {state_o, alu_op, func, pc_write, pc_write_cond, ir_write, mem_read,
                mem_write, iord, reg_write, alu_src_a, alu_src_b, mem_to_reg, pc_src, illegal};

  int    n_total = 0;
  int    n_pass  = 0;
  vec_t  vecs[$];
  outs_t sb_q[$];

  // Fields of the instruction currently being added to the table.
  logic [6:0] cur_opc;
  logic [2:0] cur_f3;
  logic       cur_f7;
  logic [3:0] cur_fn;

  function automatic outs_t o(logic [3:0] st, logic [1:0] aop, logic pw, logic pwc, logic irw,
                              logic mr, logic mw, logic io, logic rw, logic [1:0] sa,
                              logic [1:0] sb, logic [1:0] m2r, logic [1:0] ps, logic ill);
    return '{st, aop, cur_fn, pw, pwc, irw, mr, mw, io, rw, sa, sb, m2r, ps, ill};
  endfunction

  function automatic outs_t fetch(logic rdy);
    return o(ST_FETCH, 2'b01, rdy, 1'b0, rdy, 1'b1, 1'b0, 1'b0, 1'b0,
             2'b00, 2'b01, 2'b00, 2'b00, 1'b0);
  endfunction

  function automatic outs_t decode();
    return o(ST_DEC, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
             2'b10, 2'b10, 2'b00, 2'b00, 1'b0);
  endfunction

  function automatic outs_t alu_wb();
    return o(ST_AWB, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
             2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
  endfunction

  function automatic outs_t mem_addr();
    return o(ST_MADDR, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
             2'b01, 2'b10, 2'b00, 2'b00, 1'b0);
  endfunction

  function automatic outs_t reset_outs();
    return o(ST_IDLE, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
             2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
  endfunction

  task automatic instr(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                       input logic [3:0] fn);
    cur_opc = opc;
    cur_f3  = f3;
    cur_f7  = f7;
    cur_fn  = fn;
  endtask

  task automatic row(input logic rdy, input outs_t e);
    vecs.push_back('{cur_opc, cur_f3, cur_f7, rdy, e});
  endtask

  task automatic check(input string nm, input outs_t e);
    n_total++;
    if (act === e) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got st=%0d aop=%b fn=%b pw=%b pwc=%b irw=%b mr=%b mw=%b io=%b rw=%b sa=%b sb=%b m2r=%b ps=%b ill=%b | want st=%0d aop=%b fn=%b pw=%b pwc=%b irw=%b mr=%b mw=%b io=%b rw=%b sa=%b sb=%b m2r=%b ps=%b ill=%b",
               nm, act.st, act.aop, act.fn, act.pw, act.pwc, act.irw, act.mr, act.mw, act.io,
               act.rw, act.sa, act.sb, act.m2r, act.ps, act.ill,
               e.st, e.aop, e.fn, e.pw, e.pwc, e.irw, e.mr, e.mw, e.io,
               e.rw, e.sa, e.sb, e.m2r, e.ps, e.ill);
    end
  endtask

  // Applies each vector for one cycle. Inputs are driven just after the rising edge.
  // The expectation is queued at drive time and popped for comparison at the falling edge.
  task automatic run_vecs(input string tag);
    outs_t e;
    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      opcode    = vecs[i].opc;
      funct3    = vecs[i].f3;
      funct7_5  = vecs[i].f7;
      mem_ready = vecs[i].rdy;
      sb_q.push_back(vecs[i].exp);
      @(negedge clk);
      e = sb_q.pop_front();
      check($sformatf("%s_row%0d", tag, i), e);
    end
    vecs.delete();
  endtask

  initial begin
    rst_n     = 1'b0;
    opcode    = 7'd0;
    funct3    = 3'd0;
    funct7_5  = 1'b0;
    mem_ready = 1'b1;
    instr(7'd0, 3'd0, 1'b0, 4'b0000);

    // Every output is zero while reset is held, even with mem_ready high.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("reset_hold%0d", i), reset_outs());
    end
    #2 rst_n = 1'b1;

    // ADD: R-type, funct7_5 passes through to func. mem_ready low outside memory states is ignored.
    instr(7'b0110011, 3'b000, 1'b1, 4'b1000);
    row(1'b1, fetch(1'b1));
    row(1'b0, decode());
    row(1'b0, o(ST_EXR, 2'b10, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 0));
    row(1'b1, alu_wb());
    // ADDI with IR[30]=1 must not become SUB.
    instr(7'b0010011, 3'b000, 1'b1, 4'b0000);
    row(1'b1, fetch(1'b1));
    row(1'b1, decode());
    row(1'b1, o(ST_EXI, 2'b10, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b00, 2'b00, 0));
    row(1'b1, alu_wb());
    // SRAI keeps IR[30].
    instr(7'b0010011, 3'b101, 1'b1, 4'b1101);
    row(1'b1, fetch(1'b1));
    row(1'b1, decode());
    row(1'b1, o(ST_EXI, 2'b10, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b00, 2'b00, 0));
    row(1'b1, alu_wb());
    // LW with three wait cycles takes eight cycles in total.
    instr(7'b0000011, 3'b010, 1'b0, 4'b0010);
    row(1'b1, fetch(1'b1));
    row(1'b1, decode());
    row(1'b1, mem_addr());
    for (int i = 0; i < 3; i++) begin
      row(1'b0, o(ST_MRD, 2'b00, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0));
    end
    row(1'b1, o(ST_MRD, 2'b00, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0));
    row(1'b1, o(ST_MWB, 2'b00, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b01, 2'b00, 0));
    // BNE takes three cycles.
    instr(7'b1100011, 3'b001, 1'b0, 4'b0001);
    row(1'b1, fetch(1'b1));
    row(1'b1, decode());
    row(1'b1, o(ST_BR, 2'b11, 0, 1, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b01, 0));
    // JALR with IR[30] set: func bit 3 stays clear.
    instr(7'b1100111, 3'b000, 1'b1, 4'b0000);
    row(1'b1, fetch(1'b1));
    row(1'b1, decode());
    row(1'b1, o(ST_JALR, 2'b01, 1, 0, 0, 0, 0, 0, 1, 2'b01, 2'b10, 2'b10, 2'b10, 0));
    // SW with one fetch wait and one write wait.
    instr(7'b0100011, 3'b010, 1'b0, 4'b0010);
    row(1'b0, fetch(1'b0));
    row(1'b1, fetch(1'b1));
    row(1'b1, decode());
    row(1'b1, mem_addr());
    row(1'b0, o(ST_MWR, 2'b00, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0));
    row(1'b1, o(ST_MWR, 2'b00, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0));
    // JAL.
    instr(7'b1101111, 3'b111, 1'b1, 4'b0111);
    row(1'b1, fetch(1'b1));
    row(1'b1, decode());
    row(1'b1, o(ST_JAL, 2'b00, 1, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b10, 2'b01, 0));
    // LUI: IR[30] is not passed through.
    instr(7'b0110111, 3'b101, 1'b1, 4'b0101);
    row(1'b1, fetch(1'b1));
    row(1'b1, decode());
    row(1'b1, o(ST_LUI, 2'b01, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b10, 2'b00, 2'b00, 0));
    row(1'b1, alu_wb());
    // AUIPC.
    instr(7'b0010111, 3'b000, 1'b0, 4'b0000);
    row(1'b1, fetch(1'b1));
    row(1'b1, decode());
    row(1'b1, o(ST_AUIPC, 2'b01, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b10, 2'b00, 2'b00, 0));
    row(1'b1, alu_wb());
    // Illegal opcode: the FSM traps and the flag is sticky.
    instr(7'b1111111, 3'b000, 1'b0, 4'b0000);
    row(1'b1, fetch(1'b1));
    row(1'b1, decode());
    for (int i = 0; i < 3; i++) begin
      row(1'b1, o(ST_ILL, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1));
    end
    run_vecs("main");

    // Reset from the illegal trap clears the flag.
    opcode   = 7'd0;
    funct3   = 3'd0;
    funct7_5 = 1'b0;
    instr(7'd0, 3'd0, 1'b0, 4'b0000);
    #2 rst_n = 1'b0;
    #1 check("ill_clear_async", reset_outs());
    @(negedge clk);
    check("ill_clear_held", reset_outs());
    #2 rst_n = 1'b1;

    // Store stalled in MEM_WR, then aborted by reset.
    instr(7'b0100011, 3'b000, 1'b0, 4'b0000);
    row(1'b1, fetch(1'b1));
    row(1'b1, decode());
    row(1'b1, mem_addr());
    row(1'b0, o(ST_MWR, 2'b00, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0));
    row(1'b0, o(ST_MWR, 2'b00, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0));
    run_vecs("abort");
    #2 rst_n = 1'b0;
    #1 check("abort_async_drop", reset_outs());
    mem_ready = 1'b1;
    @(negedge clk);
    check("abort_no_write", reset_outs());
    #2 rst_n = 1'b1;

    // Restart after the abort: idle hold, then a fresh fetch.
    row(1'b1, fetch(1'b1));
    row(1'b1, decode());
    run_vecs("restart");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rv32i_mc_control_fsm.md
Name: rv32i_mc_control_fsm

Overview:
Main sequencer for the RV32I multicycle core. It walks each instruction through fetch, decode, execute, memory and write-back states and drives the datapath enables, mux selects and the 2-bit alu_op consumed by the ALU control decoder. It also assembles the 4-bit {funct7[5],funct3} func field for that decoder. Memory accesses use a ready handshake, so wait states of any length are tolerated.

Parameters:
RESET_PC_HOLD, 1, cycles spent in S_IDLE after reset deassertion before the first fetch (1..15)

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
opcode  input  7  IR[6:0], valid from S_DECODE onward
funct3  input  3  IR[14:12]
funct7_5  input  1  IR[30]
mem_ready  input  1  memory completes the current read/write this cycle
alu_op  output  2  00 idle/J, 01 add, 10 R/I decode, 11 branch
func  output  4  {f7b, funct3} to ALU control
pc_write  output  1  unconditional PC load
pc_write_cond  output  1  PC load gated by branch-taken
ir_write  output  1  latch instruction register
mem_read  output  1  memory read request
mem_write  output  1  memory write request
iord  output  1  0 = PC address, 1 = ALUOut address
reg_write  output  1  register file write
alu_src_a  output  2  00 PC, 01 rs1, 10 oldPC, 11 zero
alu_src_b  output  2  00 rs2, 01 const 4, 10 imm
mem_to_reg  output  2  00 ALUOut, 01 MDR, 10 PC+4
pc_src  output  2  00 ALU result, 01 ALUOut, 10 ALU result & ~1
illegal  output  1  sticky illegal-opcode flag
state_o  output  4  current state, for debug

Behaviour:
- Reset: while rst_n=0, state=S_IDLE, the hold counter is 0, illegal=0 and every output is 0. Reset asserted mid-instruction aborts immediately; no write completes.
- Outputs are Moore, decoded from the state register. func is combinational from the IR fields.
- func: f7b=funct7_5 for opcode 0110011 (R-type), and for 0010011 with funct3=101 (SRLI/SRAI). Otherwise f7b=0, so ADDI is never decoded as SUB.
- S_IDLE: stay RESET_PC_HOLD cycles, then go to S_FETCH.
- S_FETCH: mem_read=1, iord=0, alu_src_a=00, alu_src_b=01, alu_op=01.
  - When mem_ready=1: ir_write=1, pc_write=1, pc_src=00, next state S_DECODE.
  - Otherwise hold S_FETCH with all outputs held.
- S_DECODE: alu_src_a=10, alu_src_b=10, alu_op=01 (branch target into ALUOut). Dispatch on opcode:
  - 0110011 -> S_EXEC_R
  - 0010011 -> S_EXEC_I
  - 0000011 or 0100011 -> S_MEM_ADDR
  - 1100011 -> S_BRANCH
  - 1101111 -> S_JAL
  - 1100111 -> S_JALR
  - 0110111 -> S_LUI
  - 0010111 -> S_AUIPC
  - anything else -> S_ILLEGAL
- S_EXEC_R: alu_src_a=01, alu_src_b=00, alu_op=10, then S_ALU_WB.
- S_EXEC_I: as S_EXEC_R but alu_src_b=10, then S_ALU_WB.
- S_ALU_WB: reg_write=1, mem_to_reg=00, then S_FETCH.
- S_MEM_ADDR: alu_src_a=01, alu_src_b=10, alu_op=01. Next state S_MEM_RD for a load, S_MEM_WR for a store.
- S_MEM_RD: mem_read=1, iord=1. Hold until mem_ready, then S_MEM_WB.
- S_MEM_WB: reg_write=1, mem_to_reg=01, then S_FETCH.
- S_MEM_WR: mem_write=1, iord=1. Hold until mem_ready, then S_FETCH.
- S_BRANCH: alu_src_a=01, alu_src_b=00, alu_op=11, pc_write_cond=1, pc_src=01, then S_FETCH.
- S_JAL: reg_write=1, mem_to_reg=10, pc_write=1, pc_src=01, alu_op=00, then S_FETCH.
- S_JALR: alu_src_a=01, alu_src_b=10, alu_op=01, pc_write=1, pc_src=10, reg_write=1, mem_to_reg=10, then S_FETCH.
- S_LUI: alu_src_a=11, alu_src_b=10, alu_op=01, then S_ALU_WB.
- S_AUIPC: alu_src_a=10, alu_src_b=10, alu_op=01, then S_ALU_WB.
- S_ILLEGAL: sets illegal=1 (sticky until reset) and stays in S_ILLEGAL. No PC or register file write.
- mem_ready outside a memory state is ignored. There are no outstanding requests across state changes.
- Cycle counts with mem_ready already high:
  - R/I-type: 4
  - load: 5
  - store: 4
  - branch, JAL, JALR: 3
  - LUI/AUIPC: 4
- Each wait cycle adds 1.
- Unused state encodings go to S_IDLE on the next clock.

Test Plan:
- rst_n=0 then released, RESET_PC_HOLD=1, mem_ready=1 -> all outputs 0 during reset; S_FETCH is reached 1 cycle after release with mem_read=1.
- ADD (opcode 0110011, funct7_5=1, funct3=000) -> states FETCH, DECODE, EXEC_R, ALU_WB; func=4'b1000 with alu_op=10 in EXEC_R; reg_write=1 for exactly 1 cycle.
- ADDI with IR[30]=1 -> func=4'b0000 in EXEC_I. SRAI (funct3=101, IR[30]=1) -> func=4'b1101.
- LW with mem_ready low for 3 cycles in MEM_RD -> mem_read and iord held high for 4 cycles; instruction takes 8 cycles; reg_write with mem_to_reg=01.
- BNE (funct3=001) -> alu_op=11, func[2:0]=001, pc_write_cond=1 in BRANCH; back to FETCH after 3 cycles. JALR -> pc_src=10, mem_to_reg=10.
- opcode 1111111 -> illegal rises in the cycle after DECODE and stays high. rst_n pulsed during MEM_WR -> mem_write drops asynchronously and illegal clears.
